div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage. It raises

---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants for the divide unit, hazard unit and HI/LO register.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, trial-subtract
// the divisor, keep the difference and set the quotient bit when it fits.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // The shifted remainder needs WIDTH+1 bits; the kept value always fits WIDTH
  // because the remainder stays below the divisor.
  always_comb begin
    rem_sh  = {rem_in, quo_in[WIDTH-1]};
    diff    = rem_sh - {1'b0, divisor};
    quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
    rem_out = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the pipeline through stall_div and strobes result_valid for HI/LO write.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall_div,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             sign_a, sign_b;
  logic             neg_a, neg_b;

  assign neg_a = div_signed & opa[WIDTH-1];
  assign neg_b = div_signed & opb[WIDTH-1];
  assign abs_a = neg_a ? -opa : opa;
  assign abs_b = neg_b ? -opb : opb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Quotient is negative when signs differ, remainder follows the dividend.
  // The most-negative / -1 case wraps back to itself, which is the wanted result.
  assign quo_fix = (sign_a ^ sign_b) ? -quo_nxt : quo_nxt;
  assign rem_fix = sign_a ? -rem_nxt : rem_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; annul overrides everything.
  always_comb begin
    state_nxt    = state;
    stall_div    = 1'b0;
    result_valid = 1'b0;
    if (annul) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            stall_div = 1'b1;
            state_nxt = (opb == '0) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          stall_div = 1'b1;
          if (count == CNT_LAST) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          result_valid = 1'b1;
          state_nxt    = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      lo_out    <= '0;
      hi_out    <= '0;
    end else if (!annul) begin
      case (state)
        ST_IDLE: begin
          if (div_start) begin
            quo_q     <= abs_a;
            rem_q     <= '0;
            divisor_q <= abs_b;
            sign_a    <= neg_a;
            sign_b    <= neg_b;
            count     <= '0;
            if (opb == '0) begin
              lo_out <= '1;
              hi_out <= opa;
            end
          end
        end
        ST_BUSY: begin
          quo_q <= quo_nxt;
          rem_q <= rem_nxt;
          count <= count + 1'b1;
          if (count == CNT_LAST) begin
            lo_out <= quo_fix;
            hi_out <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// compared against plain-arithmetic expectations.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_start;
  logic         div_signed;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         annul;
  logic         stall_div;
  logic         result_valid;
  logic [W-1:0] lo_out;
  logic [W-1:0] hi_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rv_cyc = 0;
  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .opa          (opa),
    .opb          (opb),
    .annul        (annul),
    .stall_div    (stall_div),
    .result_valid (result_valid),
    .lo_out       (lo_out),
    .hi_out       (hi_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called just after a falling edge; returns just after the falling edge of
  // the result cycle (keep=1) or of the following idle cycle (keep=0).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input bit keep, input string tag);
    logic [W-1:0] eq, er;
    int stalls, c, exp_st;
    bit got;
    model(a, b, sgn, eq, er);
    exp_st = (b == '0) ? 1 : W + 1;
    opa = a;
    opb = b;
    div_signed = sgn;
    div_start = 1'b1;
    stalls = 0;
    got = 1'b0;
    for (c = 0; c < 80; c++) begin
      #1;
      if (result_valid) begin
        got = 1'b1;
        break;
      end
      if (stall_div) stalls++;
      @(negedge clk);
    end
    chk($sformatf("%s/result_seen", tag), W'(got), 1);
    if (got) begin
      chk($sformatf("%s/stall_cycles", tag), stalls, exp_st);
      chk($sformatf("%s/latency", tag), c, exp_st);
      chk($sformatf("%s/stall_in_done", tag), W'(stall_div), 0);
      chk($sformatf("%s/lo", tag), lo_out, eq);
      chk($sformatf("%s/hi", tag), hi_out, er);
      last_rv_cyc = cyc;
      last_lo = eq;
      last_hi = er;
    end
    if (!keep) begin
      div_start = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("%s/rv_one_cycle", tag), W'(result_valid), 0);
      chk($sformatf("%s/lo_hold", tag), lo_out, last_lo);
    end
  endtask

  initial begin
    int t1, pulses;
    logic [W-1:0] a, b;
    rst = 1'b1;
    div_start = 1'b0;
    div_signed = 1'b0;
    opa = '0;
    opb = '0;
    annul = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset/stall", W'(stall_div), 0);
    chk("reset/rv", W'(result_valid), 0);
    chk("reset/lo", lo_out, 0);
    chk("reset/hi", hi_out, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "divu_max_1");
    run_div(32'h1234, 32'd0, 1'b0, 1'b0, "div_by_zero");
    run_div(32'hFFFF_FF00, 32'd0, 1'b1, 1'b0, "sdiv_by_zero");

    // Annul part-way through a divide.
    opa = 32'd1000;
    opb = 32'd3;
    div_signed = 1'b0;
    div_start = 1'b1;
    repeat (5) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul/stall", W'(stall_div), 0);
    chk("annul/rv", W'(result_valid), 0);
    @(negedge clk);
    annul = 1'b0;
    div_start = 1'b0;
    #1;
    chk("annul/idle_stall", W'(stall_div), 0);
    chk("annul/lo_hold", lo_out, last_lo);
    chk("annul/hi_hold", hi_out, last_hi);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (result_valid) pulses++;
    end
    chk("annul/no_result", pulses, 0);
    run_div(32'd9, 32'd3, 1'b0, 1'b0, "after_annul");

    // Annul together with start must not launch a divide.
    opa = 32'h55;
    opb = 32'd0;
    div_start = 1'b1;
    annul = 1'b1;
    #1;
    chk("annul_start/stall", W'(stall_div), 0);
    @(negedge clk);
    annul = 1'b0;
    div_start = 1'b0;
    #1;
    chk("annul_start/rv", W'(result_valid), 0);
    chk("annul_start/lo_hold", lo_out, last_lo);

    // Back-to-back with div_start held high.
    @(negedge clk);
    run_div(32'd50, 32'd5, 1'b0, 1'b1, "b2b_first");
    t1 = last_rv_cyc;
    @(negedge clk);
    run_div(32'd51, 32'd5, 1'b0, 1'b0, "b2b_second");
    chk("b2b/pulse_gap", last_rv_cyc - t1, W + 2);

    // Reset in the middle of a divide.
    opa = 32'd77;
    opb = 32'd5;
    div_start = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    div_start = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst/stall", W'(stall_div), 0);
    chk("mid_rst/rv", W'(result_valid), 0);
    chk("mid_rst/lo", lo_out, 0);
    chk("mid_rst/hi", hi_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Random divides.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom;
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = -($urandom_range(1, 100));
      endcase
      run_div(a, b, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
